alu_op_sequencer: RTL

//  Sequences the shared 8-bit ALU for 6502-style arithmetic/logic/shift ops.

---
 rtl/alu_seq_pkg.sv | 46 ++++
 rtl/alu_op_decode.sv | 130 +++++++++++++
 rtl/alu_op_sequencer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_seq_pkg.sv
// Shared constants for the ALU op sequencer: opcode values, FSM state encoding,
// ALU enable-vector bit positions and flag-source selects.
package alu_seq_pkg;

   // Opcodes carried on req_op; 13..15 are illegal
   localparam logic [3:0] OP_ADC = 4'd0;
   localparam logic [3:0] OP_SBC = 4'd1;
   localparam logic [3:0] OP_AND = 4'd2;
   localparam logic [3:0] OP_EOR = 4'd3;
   localparam logic [3:0] OP_ORA = 4'd4;
   localparam logic [3:0] OP_CMP = 4'd5;
   localparam logic [3:0] OP_BIT = 4'd6;
   localparam logic [3:0] OP_ASL = 4'd7;
   localparam logic [3:0] OP_LSR = 4'd8;
   localparam logic [3:0] OP_ROL = 4'd9;
   localparam logic [3:0] OP_ROR = 4'd10;
   localparam logic [3:0] OP_INC = 4'd11;
   localparam logic [3:0] OP_DEC = 4'd12;

   // FSM state encoding
   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_PASS1 = 2'd1;
   localparam logic [1:0] ST_PASS2 = 2'd2;
   localparam logic [1:0] ST_RESP  = 2'd3;

   // ALU enable vector bit positions. SUM..SR are the function selects (one-hot or zero);
   // INV is a B-inversion modifier that only ever accompanies SUM.
   localparam int unsigned EN_SUM = 0;
   localparam int unsigned EN_AND = 1;
   localparam int unsigned EN_EOR = 2;
   localparam int unsigned EN_OR  = 3;
   localparam int unsigned EN_SR  = 4;
   localparam int unsigned EN_INV = 5;
   localparam int unsigned EN_W   = 6;

   // Carry flag source
   localparam logic [1:0] CSEL_PASS = 2'd0;  // keep req_c
   localparam logic [1:0] CSEL_COUT = 2'd1;  // ALU carry out of the final pass
   localparam logic [1:0] CSEL_ROR  = 2'd2;  // carry out captured in pass 1

   // Overflow flag source
   localparam logic [1:0] VSEL_PASS = 2'd0;  // keep req_v
   localparam logic [1:0] VSEL_ADD  = 2'd1;  // signed overflow of A + Bint
   localparam logic [1:0] VSEL_BIT  = 2'd2;  // B[6]

endpackage

// File: rtl/alu_op_decode.sv
// Combinational op decoder for the ALU sequencer.
// Inputs : op, pass1/pass2 (current pass), latched a/b/c, res1 (pass-1 result for ROR).
// Outputs: ALU enable vector, alu_a/alu_b/alu_cin, rsp write-back, two-pass flag,
//          illegal flag, carry/overflow source selects, n_from_b (BIT takes N from B).
// Operands and enables are zero whenever neither pass is active.
module alu_op_decode
   import alu_seq_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic [3:0]      op,
   input  logic            pass1,
   input  logic            pass2,
   input  logic [W-1:0]    a,
   input  logic [W-1:0]    b,
   input  logic            c,
   input  logic [W-1:0]    res1,
   output logic [EN_W-1:0] en,
   output logic [W-1:0]    alu_a,
   output logic [W-1:0]    alu_b,
   output logic            alu_cin,
   output logic            wr,
   output logic            two_pass,
   output logic            err,
   output logic [1:0]      c_sel,
   output logic [1:0]      v_sel,
   output logic            n_from_b
);

   always_comb begin
      en       = '0;
      alu_a    = '0;
      alu_b    = '0;
      alu_cin  = 1'b0;
      wr       = 1'b1;
      two_pass = 1'b0;
      err      = 1'b0;
      c_sel    = CSEL_PASS;
      v_sel    = VSEL_PASS;
      n_from_b = 1'b0;
      case (op)
         OP_ADC, OP_SBC: begin
            c_sel = CSEL_COUT;
            v_sel = VSEL_ADD;
            if (pass1) begin
               en[EN_SUM] = 1'b1;
               en[EN_INV] = (op == OP_SBC);
               alu_a      = a;
               alu_b      = b;
               alu_cin    = c;
            end
         end
         OP_AND, OP_EOR, OP_ORA: begin
            if (pass1) begin
               en[EN_AND] = (op == OP_AND);
               en[EN_EOR] = (op == OP_EOR);
               en[EN_OR]  = (op == OP_ORA);
               alu_a      = a;
               alu_b      = b;
            end
         end
         OP_CMP: begin
            c_sel = CSEL_COUT;
            wr    = 1'b0;
            if (pass1) begin
               en[EN_SUM] = 1'b1;
               en[EN_INV] = 1'b1;
               alu_a      = a;
               alu_b      = b;
               alu_cin    = 1'b1;
            end
         end
         OP_BIT: begin
            wr       = 1'b0;
            v_sel    = VSEL_BIT;
            n_from_b = 1'b1;
            if (pass1) begin
               en[EN_AND] = 1'b1;
               alu_a      = a;
               alu_b      = b;
            end
         end
         OP_ASL, OP_ROL: begin
            c_sel = CSEL_COUT;
            if (pass1) begin
               en[EN_SUM] = 1'b1;
               alu_a      = a;
               alu_b      = a;
               alu_cin    = (op == OP_ROL) ? c : 1'b0;
            end
         end
         OP_LSR: begin
            c_sel = CSEL_COUT;
            if (pass1) begin
               en[EN_SR] = 1'b1;
               alu_a     = a;
            end
         end
         OP_ROR: begin
            c_sel    = CSEL_ROR;
            two_pass = 1'b1;
            if (pass1) begin
               en[EN_SR] = 1'b1;
               alu_a     = a;
            end
         end
         OP_INC, OP_DEC: begin
            if (pass1) begin
               en[EN_SUM] = 1'b1;
               en[EN_INV] = (op == OP_DEC);
               alu_cin    = (op == OP_INC);
               alu_a      = a;
            end
         end
         default: begin
            wr  = 1'b0;
            err = 1'b1;
         end
      endcase
      // ROR second pass: OR the old carry into bit W-1 of the shifted value
      if (pass2) begin
         en         = '0;
         en[EN_OR]  = 1'b1;
         alu_a      = res1;
         alu_b      = {c, {(W-1){1'b0}}};
         alu_cin    = 1'b0;
      end
   end

endmodule

// File: rtl/alu_op_sequencer.sv
// Sequences the shared 8-bit ALU for 6502-style arithmetic/logic/shift ops.
// Ports: clk/rst_n; request handshake req_valid/req_ready with req_op/a/b/c/v;
//        response handshake rsp_valid/rsp_ready with rsp_res/wr/n/z/c/v/err;
//        ALU controls alu_*_en, operands alu_a/alu_b/alu_cin; ALU returns alu_res/alu_cout.
// One request is taken in IDLE, run for one pass (two for ROR), and the registered
// result is held in RESP until rsp_ready.
module alu_op_sequencer
   import alu_seq_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req_valid,
   output logic         req_ready,
   input  logic [3:0]   req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   input  logic         req_c,
   input  logic         req_v,
   output logic         rsp_valid,
   input  logic         rsp_ready,
   output logic [W-1:0] rsp_res,
   output logic         rsp_wr,
   output logic         rsp_n,
   output logic         rsp_z,
   output logic         rsp_c,
   output logic         rsp_v,
   output logic         rsp_err,
   output logic         alu_sum_en,
   output logic         alu_and_en,
   output logic         alu_eor_en,
   output logic         alu_or_en,
   output logic         alu_sr_en,
   output logic         alu_inv_en,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic         alu_cin,
   input  logic [W-1:0] alu_res,
   input  logic         alu_cout
);

   logic [1:0]      state_q, state_d;
   logic [3:0]      op_q;
   logic [W-1:0]    a_q, b_q, res1_q;
   logic            c_q, v_q, cout1_q;
   logic [W-1:0]    rsp_res_q;
   logic            rsp_wr_q, rsp_n_q, rsp_z_q, rsp_c_q, rsp_v_q, rsp_err_q;

   logic            pass1, pass2, accept, load_rsp;
   logic [EN_W-1:0] en;
   logic            wr, two_pass, err, n_from_b;
   logic [1:0]      c_sel, v_sel;
   logic [W-1:0]    res_fin;
   logic            n_fin, z_fin, c_fin, v_fin, bint_msb, v_add;

   assign pass1    = (state_q == ST_PASS1);
   assign pass2    = (state_q == ST_PASS2);
   assign accept   = (state_q == ST_IDLE) && req_valid;
   assign load_rsp = (pass1 && !two_pass) || pass2;

   alu_op_decode #(
      .W (W)
   ) u_decode (
      .op       (op_q),
      .pass1    (pass1),
      .pass2    (pass2),
      .a        (a_q),
      .b        (b_q),
      .c        (c_q),
      .res1     (res1_q),
      .en       (en),
      .alu_a    (alu_a),
      .alu_b    (alu_b),
      .alu_cin  (alu_cin),
      .wr       (wr),
      .two_pass (two_pass),
      .err      (err),
      .c_sel    (c_sel),
      .v_sel    (v_sel),
      .n_from_b (n_from_b)
   );

   assign {alu_inv_en, alu_sr_en, alu_or_en, alu_eor_en, alu_and_en, alu_sum_en} = en;

   // Final result/flags, sampled into the response registers on the last pass
   always_comb begin
      res_fin  = err ? a_q : alu_res;
      n_fin    = n_from_b ? b_q[W-1] : res_fin[W-1];
      z_fin    = (res_fin == '0);
      // ALU overflow ignores inversion, so rebuild the effective B sign bit here
      bint_msb = alu_inv_en ? ~alu_b[W-1] : alu_b[W-1];
      v_add    = (alu_a[W-1] ~^ bint_msb) & (alu_a[W-1] ^ res_fin[W-1]);
      case (c_sel)
         CSEL_COUT: c_fin = alu_cout;
         CSEL_ROR:  c_fin = cout1_q;
         default:   c_fin = c_q;
      endcase
      case (v_sel)
         VSEL_ADD: v_fin = v_add;
         VSEL_BIT: v_fin = b_q[W-2];
         default:  v_fin = v_q;
      endcase
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid) state_d = ST_PASS1;
         ST_PASS1: state_d = two_pass ? ST_PASS2 : ST_RESP;
         ST_PASS2: state_d = ST_RESP;
         ST_RESP:  if (rsp_ready) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         v_q     <= 1'b0;
         res1_q  <= '0;
         cout1_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if (accept) begin
            op_q <= req_op;
            a_q  <= req_a;
            b_q  <= req_b;
            c_q  <= req_c;
            v_q  <= req_v;
         end
         if (pass1 && two_pass) begin
            res1_q  <= alu_res;
            cout1_q <= alu_cout;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_res_q <= '0;
         rsp_wr_q  <= 1'b0;
         rsp_n_q   <= 1'b0;
         rsp_z_q   <= 1'b0;
         rsp_c_q   <= 1'b0;
         rsp_v_q   <= 1'b0;
         rsp_err_q <= 1'b0;
      end else if (load_rsp) begin
         rsp_res_q <= res_fin;
         rsp_wr_q  <= wr;
         rsp_n_q   <= n_fin;
         rsp_z_q   <= z_fin;
         rsp_c_q   <= c_fin;
         rsp_v_q   <= v_fin;
         rsp_err_q <= err;
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_res   = rsp_res_q;
   assign rsp_wr    = rsp_wr_q;
   assign rsp_n     = rsp_n_q;
   assign rsp_z     = rsp_z_q;
   assign rsp_c     = rsp_c_q;
   assign rsp_v     = rsp_v_q;
   assign rsp_err   = rsp_err_q;

endmodule
